// File: rtl/alu_ctrl_if.sv
// Request/response channel bundle between the instruction path and alu_ctrl.
// Latency: none (wires only).
// Backpressure: valid/ready on both channels; master drives req_* and rsp_ready.
//
// Ports (per channel):
//   request : req_valid, req_ready, req_func, req_a, req_b, req_ci
//   response: rsp_valid, rsp_ready, rsp_data, rsp_co, rsp_err
// Modports: master = instruction-path side, slave = alu_ctrl side.
interface alu_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FUNC_WIDTH = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic [FUNC_WIDTH-1:0] req_func;
    logic [DATA_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_b;
    logic                  req_ci;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_co;
    logic                  rsp_err;

    modport master (
        output req_valid, req_func, req_a, req_b, req_ci, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_co, rsp_err
    );

    modport slave (
        input  req_valid, req_func, req_a, req_b, req_ci, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_co, rsp_err
    );
endinterface

// File: rtl/alu_ctrl.sv
// Request-side sequencer for the combinational ALU: validate, drive, settle, capture, respond.
// Latency: legal op responds after accept edge + SETTLE_CYCLES; rejected op after accept edge + 1.
// Backpressure: req_ready is a registered state decode; rsp_* held stable until rsp_ready.
//
// Ports:
//   clk, rst             : single clock, synchronous active-high reset
//   bus (alu_ctrl_if)    : request channel in, response channel out
//   alu_a/alu_b/alu_ci/alu_f : registered ALU inputs (alu_f = 0 is NoOp)
//   alu_s/alu_co         : ALU result and carry, captured after the settle time
// Build option: define ALU_CTRL_QUEUE_EN to place a 2-entry request FIFO in front of the FSM.
// SETTLE_CYCLES must lie in 1..15 (4-bit settle counter).
module alu_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int FUNC_WIDTH    = 5,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_ctrl_if.slave             bus,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic                  alu_ci,
    output logic [FUNC_WIDTH-1:0] alu_f,
    input  logic [DATA_WIDTH-1:0] alu_s,
    input  logic                  alu_co
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [FUNC_WIDTH-1:0] func;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic                  ci;
    } req_t;

    localparam logic [FUNC_WIDTH-1:0] FUNC_NOOP = '0;
    localparam logic [FUNC_WIDTH-1:0] FUNC_DIV  = FUNC_WIDTH'(4);
    localparam logic [FUNC_WIDTH-1:0] FUNC_MOD  = FUNC_WIDTH'(5);
    localparam logic [FUNC_WIDTH-1:0] FUNC_MAX  = FUNC_WIDTH'(22);
    localparam logic [3:0]            SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic                  err_pend;
    logic                  rdy_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_co_q;
    logic                  rsp_err_q;

    req_t                  in_req;
    req_t                  head;
    logic                  pop;
    logic                  head_err;

    assign in_req = '{func: bus.req_func, a: bus.req_a, b: bus.req_b, ci: bus.req_ci};

`ifdef ALU_CTRL_QUEUE_EN
    // Two-entry request FIFO; the FSM takes the head whenever it is idle.
    req_t       fifo_mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [1:0] count_nxt;
    logic       push;

    assign push = bus.req_valid && rdy_q;
    assign pop  = (state == IDLE) && (count != 2'd0);
    assign head = fifo_mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 2'd1;
        end else if (!push && pop) begin
            count_nxt = count - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            rdy_q  <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= in_req;
                wr_ptr           <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            count <= count_nxt;
            // Ready mirrors "not full" for the coming cycle, so it stays a pure flop output.
            rdy_q <= (count_nxt != 2'd2);
        end
    end
`else
    // No queue: the request is taken straight off the bus while idle.
    assign pop  = bus.req_valid && rdy_q;
    assign head = in_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q <= 1'b0;
        end else begin
            // rdy_q implies IDLE; held low through the reset cycle itself.
            rdy_q <= (state_nxt == IDLE);
        end
    end
`endif

    assign head_err = (head.func > FUNC_MAX) ||
                      (((head.func == FUNC_DIV) || (head.func == FUNC_MOD)) && (head.b == '0));

    // Next-state logic. A rejected request also passes through DRIVE for one
    // cycle (ALU left at NoOp) so its response appears one edge after accept.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            err_pend   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ci     <= 1'b0;
            alu_f      <= FUNC_NOOP;
            rsp_data_q <= '0;
            rsp_co_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pop) begin
                        err_pend <= head_err;
                        if (head_err) begin
                            cnt <= 4'd1;
                        end else begin
                            cnt    <= SETTLE_INIT;
                            alu_a  <= head.a;
                            alu_b  <= head.b;
                            alu_ci <= head.ci;
                            alu_f  <= head.func;
                        end
                    end
                end
                DRIVE: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        // Counter reaches zero on this edge: capture and park the ALU at NoOp.
                        alu_f      <= FUNC_NOOP;
                        rsp_err_q  <= err_pend;
                        rsp_data_q <= err_pend ? '0 : alu_s;
                        rsp_co_q   <= err_pend ? 1'b0 : alu_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready = rdy_q;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_co    = rsp_co_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
